// File: rtl/generador_texto_pkg.sv
// Shared constants and types for the text-line generator.
package generador_texto_pkg;

    localparam int CHAR_W = 8;
    localparam int CHAR_H = 16;
    localparam int ROM_AW = 11;

    localparam logic [6:0] SPACE = 7'h20;

    localparam logic [2:0] COLOR_BLACK = 3'b000;
    localparam logic [2:0] COLOR_WHITE = 3'b111;

    // Per-pixel attributes that travel alongside the font ROM access so they
    // line up with font_word when the colour is finally chosen.
    typedef struct packed {
        logic       videoOn;
        logic       inRegion;
        logic [2:0] col;
        logic       cursorHit;
    } pix_tag_t;

    // Address width for n slots, never narrower than one bit.
    function automatic int addrWidth(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/generador_texto_text_buffer.sv
// Character buffer: one 7-bit code per slot, synchronous write, combinational read.
module text_buffer
    import generador_texto_pkg::*;
#(
    parameter int N_CHARS = 8,
    parameter int AW      = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [6:0]    wr_char_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [6:0]    rd_char_o
);

    logic [6:0] slots_q [N_CHARS];
    logic       wrValid;
    logic       rdValid;

    // Addresses beyond the last slot are legal to present but must not touch
    // the buffer (writes) or index past it (reads, which fall back to a space).
    always_comb begin
        wrValid = wr_en_i && ({1'b0, wr_addr_i} < (AW+1)'(N_CHARS));
        rdValid = {1'b0, rd_addr_i} < (AW+1)'(N_CHARS);
    end

    // Slot storage: reset fills the line with spaces and wins over any write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CHARS; i++) begin
                slots_q[i] <= SPACE;
            end
        end else if (wrValid) begin
            slots_q[wr_addr_i] <= wr_char_i;
        end
    end

    // Read port sees the pre-write contents during the writing cycle.
    always_comb begin
        rd_char_o = SPACE;
        if (rdValid) begin
            rd_char_o = slots_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/generador_texto.sv
// One-line text overlay: buffer lookup, external font ROM access, colour stage
// and a blinking cursor, with three clock cycles from pixel to colour.
module generador_texto
    import generador_texto_pkg::*;
#(
    parameter int          N_CHARS      = 8,
    parameter int          X0           = 0,
    parameter int          Y0           = 0,
    parameter logic [2:0]  FG           = COLOR_WHITE,
    parameter logic [2:0]  BG           = COLOR_BLACK,
    parameter int          BLINK_FRAMES = 30,
    localparam int         AW           = addrWidth(N_CHARS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              video_on,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    input  logic              frame_tick,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [6:0]        wr_char,
    input  logic              cursor_en,
    input  logic [AW-1:0]     cursor_pos,
    input  logic [7:0]        font_word,
    output logic [ROM_AW-1:0] rom_addr,
    output logic [2:0]        rgb_text,
    output logic              text_on
);

    localparam int         BCW    = (BLINK_FRAMES <= 1) ? 1 : $clog2(BLINK_FRAMES);
    localparam logic [11:0] X_LO  = 12'(X0);
    localparam logic [11:0] Y_LO  = 12'(Y0);
    localparam logic [11:0] X_LEN = 12'(CHAR_W * N_CHARS);
    localparam logic [11:0] Y_LEN = 12'(CHAR_H);

    logic [11:0]       relX;
    logic [11:0]       relY;
    logic              inRegion;
    logic [8:0]        cellIdx;
    logic [AW-1:0]     rdAddr;
    logic [6:0]        rdChar;
    logic              cursorHit;

    logic [ROM_AW-1:0] romAddr_q, romAddr_d;
    pix_tag_t          tag1_q, tag1_d;
    pix_tag_t          tag2_q;
    logic [2:0]        rgb_q, rgb_d;
    logic              textOn_q, textOn_d;
    logic [BCW-1:0]    blinkCnt_q, blinkCnt_d;
    logic              blinkPhase_q, blinkPhase_d;
    logic              pixelBit;

    text_buffer #(
        .N_CHARS (N_CHARS),
        .AW      (AW)
    ) u_buffer (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_char_i (wr_char),
        .rd_addr_i (rdAddr),
        .rd_char_o (rdChar)
    );

    // Region decode: a pixel left of/above the line makes the 12-bit offset
    // wrap to a huge value, so one unsigned length compare per axis covers both edges.
    always_comb begin
        relX      = {2'b00, pixel_x} - X_LO;
        relY      = {2'b00, pixel_y} - Y_LO;
        inRegion  = (relX < X_LEN) && (relY < Y_LEN);
        cellIdx   = relX[11:3];
        rdAddr    = cellIdx[AW-1:0];
        cursorHit = cursor_en & blinkPhase_q & inRegion & (cellIdx == 9'(cursor_pos));
    end

    // Stage 1 next values: ROM address (space glyph outside the line) plus the pixel tag.
    always_comb begin
        romAddr_d        = {inRegion ? rdChar : SPACE, relY[3:0]};
        tag1_d.videoOn   = video_on;
        tag1_d.inRegion  = inRegion;
        tag1_d.col       = relX[2:0];
        tag1_d.cursorHit = cursorHit;
    end

    // Stage 1 registers: address to the external ROM and the first tag delay.
    always_ff @(posedge clk) begin
        if (reset) begin
            romAddr_q <= '0;
            tag1_q    <= '0;
        end else begin
            romAddr_q <= romAddr_d;
            tag1_q    <= tag1_d;
        end
    end

    // Stage 2: the ROM is reading, so the tag waits one more cycle with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag2_q <= '0;
        end else begin
            tag2_q <= tag1_q;
        end
    end

    // Stage 3 colour choice: MSB of the glyph row is the leftmost pixel, and
    // a cursor hit swaps foreground and background for the whole cell.
    always_comb begin
        pixelBit = font_word[3'd7 - tag2_q.col];
        textOn_d = tag2_q.videoOn & tag2_q.inRegion;
        rgb_d    = COLOR_BLACK;
        if (textOn_d) begin
            rgb_d = (pixelBit ^ tag2_q.cursorHit) ? FG : BG;
        end
    end

    // Stage 3 registers drive the outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q    <= COLOR_BLACK;
            textOn_q <= 1'b0;
        end else begin
            rgb_q    <= rgb_d;
            textOn_q <= textOn_d;
        end
    end

    // Blink timing: count frames and flip the cursor phase every BLINK_FRAMES ticks.
    always_comb begin
        blinkCnt_d   = blinkCnt_q;
        blinkPhase_d = blinkPhase_q;
        if (frame_tick) begin
            if (blinkCnt_q == BCW'(BLINK_FRAMES - 1)) begin
                blinkCnt_d   = '0;
                blinkPhase_d = ~blinkPhase_q;
            end else begin
                blinkCnt_d = blinkCnt_q + BCW'(1);
            end
        end
    end

    // Blink state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            blinkCnt_q   <= '0;
            blinkPhase_q <= 1'b0;
        end else begin
            blinkCnt_q   <= blinkCnt_d;
            blinkPhase_q <= blinkPhase_d;
        end
    end

    assign rom_addr = romAddr_q;
    assign rgb_text = rgb_q;
    assign text_on  = textOn_q;

endmodule

// File: tb/tb_generador_texto.sv
// Self-checking bench for generador_texto: directed scans plus random traffic
// compared against a behavioural model of the text line.
module tb_generador_texto;

    localparam int         N   = 6;
    localparam int         X0  = 16;
    localparam int         Y0  = 32;
    localparam int         BF  = 2;
    localparam logic [2:0] FGC = 3'b110;
    localparam logic [2:0] BGC = 3'b001;

    logic        clk = 1'b0;
    logic        reset;
    logic        video_on;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        frame_tick;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [6:0]  wr_char;
    logic        cursor_en;
    logic [2:0]  cursor_pos;
    logic [7:0]  font_word;
    logic [10:0] rom_addr;
    logic [2:0]  rgb_text;
    logic        text_on;

    bit          romConst;
    logic [6:0]  mBuf [N];
    int          ticks;
    logic [3:0]  pipeQ [$];
    int          checks;
    int          failures;
    logic [6:0]  holaCodes [4];

    generador_texto #(
        .N_CHARS      (N),
        .X0           (X0),
        .Y0           (Y0),
        .FG           (FGC),
        .BG           (BGC),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .video_on   (video_on),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .frame_tick (frame_tick),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_char    (wr_char),
        .cursor_en  (cursor_en),
        .cursor_pos (cursor_pos),
        .font_word  (font_word),
        .rom_addr   (rom_addr),
        .rgb_text   (rgb_text),
        .text_on    (text_on)
    );

    always #5 clk = ~clk;

    // Arbitrary but deterministic glyph rows for the model font.
    function automatic logic [7:0] fontRow(input logic [10:0] a);
        return {a[3:0], a[10:7]} ^ a[7:0] ^ 8'h3C;
    endfunction

    // Synchronous font ROM: data one clock after the address.
    always @(posedge clk) begin
        font_word <= romConst ? 8'h81 : fontRow(rom_addr);
    end

    task automatic checkOutput(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: predict from the current inputs, update the model, clock, compare.
    task automatic applyStimulus();
        int         x, y, idx, col, row;
        bit         inReg, phase, hit, bitv, wasReset;
        logic [7:0] w;
        logic [10:0] expAddr;
        logic [3:0] expPix;
        logic [3:0] e;
        x     = int'(pixel_x);
        y     = int'(pixel_y);
        row   = (y - Y0) & 15;
        inReg = (x >= X0) && (x < X0 + 8 * N) && (y >= Y0) && (y < Y0 + 16);
        if (reset) begin
            expAddr = '0;
            expPix  = '0;
        end else if (inReg) begin
            idx     = (x - X0) / 8;
            col     = (x - X0) % 8;
            expAddr = {mBuf[idx], 4'(row)};
            w       = romConst ? 8'h81 : fontRow(expAddr);
            bitv    = w[7 - col];
            phase   = ((ticks / BF) % 2) == 1;
            hit     = cursor_en && phase && (int'(cursor_pos) == idx);
            expPix  = video_on ? {1'b1, ((bitv ^ hit) ? FGC : BGC)} : 4'b0000;
        end else begin
            expAddr = {7'h20, 4'(row)};
            expPix  = '0;
        end
        if (reset) begin
            foreach (pipeQ[i]) pipeQ[i] = '0;
        end
        pipeQ.push_back(expPix);
        wasReset = reset;
        if (reset) begin
            for (int i = 0; i < N; i++) mBuf[i] = 7'h20;
            ticks = 0;
        end else begin
            if (wr_en && int'(wr_addr) < N) mBuf[wr_addr] = wr_char;
            if (frame_tick) ticks++;
        end
        @(posedge clk);
        #1;
        checkOutput("rom_addr", rom_addr, expAddr);
        if (wasReset) begin
            checkOutput("rst_rgb", {8'd0, rgb_text}, 11'd0);
            checkOutput("rst_text_on", {10'd0, text_on}, 11'd0);
        end
        if (pipeQ.size() == 3) begin
            e = pipeQ.pop_front();
            checkOutput("rgb_text", {8'd0, rgb_text}, {8'd0, e[2:0]});
            checkOutput("text_on", {10'd0, text_on}, {10'd0, e[3]});
        end
    endtask

    task automatic idle(input int n);
        video_on = 1'b0; wr_en = 1'b0; frame_tick = 1'b0;
        repeat (n) applyStimulus();
    endtask

    initial begin
        int bx [5];
        int by [5];
        bit bv [5];
        checks = 0; failures = 0; ticks = 0; romConst = 1'b0;
        holaCodes[0] = 7'h48; holaCodes[1] = 7'h4F; holaCodes[2] = 7'h4C; holaCodes[3] = 7'h41;
        for (int i = 0; i < N; i++) mBuf[i] = 7'h20;
        reset = 1'b1; video_on = 1'b0; pixel_x = '0; pixel_y = '0; frame_tick = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_char = '0; cursor_en = 1'b0; cursor_pos = '0;
        $display("[TB] reset");
        repeat (3) applyStimulus();
        reset = 1'b0;

        $display("[TB] write HOLA and scan row Y0+5");
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_char = holaCodes[i];
            applyStimulus();
        end
        wr_en = 1'b0;
        video_on = 1'b1; pixel_y = 10'(Y0 + 5);
        for (int x = X0; x < X0 + 8 * N + 4; x++) begin
            pixel_x = 10'(x);
            applyStimulus();
            if (x < X0 + 32) checkOutput("hola", rom_addr, {holaCodes[(x - X0) / 8], 4'h5});
        end
        idle(3);

        $display("[TB] constant font row, edges of the line");
        romConst = 1'b1;
        video_on = 1'b1; pixel_y = 10'(Y0);
        for (int x = X0 - 2; x < X0 + 8 * N + 2; x++) begin
            pixel_x = 10'(x);
            applyStimulus();
        end
        bx[0] = X0 + 8 * N;     by[0] = Y0 + 3;  bv[0] = 1'b1;
        bx[1] = X0;             by[1] = Y0 + 16; bv[1] = 1'b1;
        bx[2] = X0 + 3;         by[2] = Y0 + 3;  bv[2] = 1'b0;
        bx[3] = X0 - 1;         by[3] = Y0;      bv[3] = 1'b1;
        bx[4] = X0 + 8 * N - 1; by[4] = Y0 + 15; bv[4] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pixel_x = 10'(bx[i]); pixel_y = 10'(by[i]); video_on = bv[i];
            applyStimulus();
        end
        idle(3);

        $display("[TB] cursor blink on cell 2");
        cursor_en = 1'b1; cursor_pos = 3'd2;
        for (int p = 0; p < 2; p++) begin
            frame_tick = 1'b1; applyStimulus(); applyStimulus();
            frame_tick = 1'b0;
            video_on = 1'b1; pixel_y = 10'(Y0 + 1);
            for (int x = X0 + 8; x < X0 + 32; x++) begin
                pixel_x = 10'(x);
                applyStimulus();
            end
            idle(3);
        end

        $display("[TB] write collision and out-of-range writes");
        romConst = 1'b0; cursor_en = 1'b0;
        video_on = 1'b1; pixel_x = 10'(X0 + 8 * 3 + 2); pixel_y = 10'(Y0 + 7);
        wr_en = 1'b1; wr_addr = 3'd3; wr_char = 7'h5A;
        applyStimulus();
        checkOutput("wr_same_old", rom_addr, {7'h41, 4'h7});
        wr_en = 1'b0;
        applyStimulus();
        checkOutput("wr_next_new", rom_addr, {7'h5A, 4'h7});
        wr_en = 1'b1; wr_addr = 3'd6; wr_char = 7'h7F; applyStimulus();
        wr_addr = 3'd7; wr_char = 7'h7E; applyStimulus();
        wr_en = 1'b0;
        for (int i = 0; i < N; i++) begin
            pixel_x = 10'(X0 + 8 * i);
            applyStimulus();
        end
        checkOutput("wr_oob_slot5", rom_addr, {7'h20, 4'h7});

        $display("[TB] reset in the middle of a line");
        cursor_en = 1'b1; cursor_pos = 3'd0;
        frame_tick = 1'b1; applyStimulus(); applyStimulus(); frame_tick = 1'b0;
        pixel_y = 10'(Y0 + 9);
        for (int x = X0; x < X0 + 8 * N; x++) begin
            pixel_x = 10'(x);
            reset = (x == X0 + 12);
            applyStimulus();
            if (x > X0 + 12 && x < X0 + 24) checkOutput("rst_space", rom_addr, {7'h20, 4'h9});
        end
        frame_tick = 1'b1; applyStimulus(); frame_tick = 1'b0;
        for (int x = X0; x < X0 + 8; x++) begin
            pixel_x = 10'(x);
            applyStimulus();
        end
        idle(3);

        $display("[TB] random traffic");
        for (int n = 0; n < 600; n++) begin
            reset      = ($urandom_range(0, 59) == 0);
            video_on   = ($urandom_range(0, 5) != 0);
            pixel_x    = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(0, 1023))
                                                     : 10'($urandom_range(X0 - 3, X0 + 8 * N + 3));
            pixel_y    = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(0, 1023))
                                                     : 10'($urandom_range(Y0 - 2, Y0 + 17));
            frame_tick = ($urandom_range(0, 7) == 0);
            wr_en      = ($urandom_range(0, 3) == 0);
            wr_addr    = 3'($urandom_range(0, 7));
            wr_char    = 7'($urandom_range(0, 127));
            cursor_en  = ($urandom_range(0, 3) != 0);
            cursor_pos = 3'($urandom_range(0, 7));
            applyStimulus();
        end
        reset = 1'b0;
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
